// File: rtl/safe_pkg.sv
// Shared types and helpers for the combination-safe controller.
package safe_pkg;

    typedef enum logic [2:0] {
        LOCKED  = 3'd0,
        CHECK   = 3'd1,
        OPEN    = 3'd2,
        PROGRAM = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    localparam int unsigned IDX_W      = 3;
    localparam int unsigned MAX_VAL_W  = 16;
    localparam int unsigned MAX_CODE_W = 128;

    // Digit 0 occupies the most significant slice of the flat code vector.
    function automatic logic [MAX_VAL_W-1:0] get_digit(
        input logic [MAX_CODE_W-1:0] code,
        input int unsigned           idx,
        input int unsigned           digits,
        input int unsigned           val_w
    );
        logic [MAX_CODE_W-1:0] sh;
        sh = code >> ((digits - 1 - idx) * val_w);
        return sh[MAX_VAL_W-1:0] & MAX_VAL_W'((32'd1 << val_w) - 32'd1);
    endfunction

endpackage

// File: rtl/quad_step.sv
// Quadrature encoder front end: synchronises a/b and emits one-cycle step pulses.
module quad_step (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic inc,
    output logic dec
);

    logic a_s1, a_s2, a_prev;
    logic b_s1, b_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_s1   <= 1'b0;
            a_s2   <= 1'b0;
            a_prev <= 1'b0;
            b_s1   <= 1'b0;
            b_s2   <= 1'b0;
        end else begin
            a_s1   <= a;
            a_s2   <= a_s1;
            a_prev <= a_s2;
            b_s1   <= b;
            b_s2   <= b_s1;
        end
    end

    // Direction is taken from b at the moment a rises.
    assign inc = a_s2 & ~a_prev & ~b_s2;
    assign dec = a_s2 & ~a_prev &  b_s2;

endmodule

// File: rtl/safe_lock_ctrl.sv
// Combination-safe controller: dial entry, code check, lockout, auto-relock, code change.
module safe_lock_ctrl
    import safe_pkg::*;
#(
    parameter int unsigned DIGITS        = 3,
    parameter int unsigned DIGIT_MAX     = 39,
    parameter int unsigned VAL_W         = 6,
    parameter int unsigned MAX_FAIL      = 3,
    parameter int unsigned LOCKOUT_TICKS = 30000,
    parameter int unsigned OPEN_TIMEOUT  = 10000,
    parameter int unsigned div           = 1,
    parameter logic [DIGITS*VAL_W-1:0] DEFAULT_CODE = {6'd5, 6'd12, 6'd30}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             lock,
    input  logic             open,
    input  logic             doorCls,
    input  logic             set_code,
    output logic             actuateLock,
    output logic             openCls,
    output logic [2:0]       state,
    output logic [IDX_W-1:0] digit_idx,
    output logic [VAL_W-1:0] cur_val,
    output logic [2:0]       fail_cnt,
    output logic             lockout
);

    localparam int unsigned CODE_W = DIGITS * VAL_W;
    localparam int unsigned T_MAX  = (OPEN_TIMEOUT > LOCKOUT_TICKS) ? OPEN_TIMEOUT : LOCKOUT_TICKS;
    localparam int unsigned TMR_W  = $clog2(T_MAX + 1);
    localparam int unsigned DIV_W  = (div > 1) ? $clog2(div) : 1;

    state_t              fsm;
    logic [CODE_W-1:0]   code;
    logic [CODE_W-1:0]   entry;
    logic [CODE_W-1:0]   new_code;
    logic [TMR_W-1:0]    timer;
    logic [DIV_W-1:0]    pre;
    logic                tick;
    logic                match;
    logic                last_digit;

    // Button order in the vectors: {lock, open, set_code}.
    logic [2:0] btn_s1, btn_s2, btn_prev;
    logic       door_s1, door_s2;
    logic       lock_rise, open_rise, set_rise;
    logic       step_inc, step_dec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_prev <= '0;
            door_s1  <= 1'b0;
            door_s2  <= 1'b0;
        end else begin
            btn_s1   <= {lock, open, set_code};
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
            door_s1  <= doorCls;
            door_s2  <= door_s1;
        end
    end

    assign lock_rise = btn_s2[2] & ~btn_prev[2];
    assign open_rise = btn_s2[1] & ~btn_prev[1];
    assign set_rise  = btn_s2[0] & ~btn_prev[0];

    quad_step u_quad (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .inc   (step_inc),
        .dec   (step_dec)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pre <= '0;
        else if (tick)
            pre <= '0;
        else
            pre <= pre + DIV_W'(1);
    end

    assign tick = (pre == DIV_W'(div - 1));

    always_comb begin
        match    = 1'b1;
        new_code = entry;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (get_digit(MAX_CODE_W'(entry), i, DIGITS, VAL_W) !=
                get_digit(MAX_CODE_W'(code),  i, DIGITS, VAL_W))
                match = 1'b0;
            if (digit_idx == IDX_W'(i))
                new_code[(DIGITS - 1 - i) * VAL_W +: VAL_W] = cur_val;
        end
    end

    assign last_digit = (digit_idx == IDX_W'(DIGITS - 1));
    assign state      = fsm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm         <= LOCKED;
            code        <= DEFAULT_CODE;
            entry       <= '0;
            timer       <= '0;
            digit_idx   <= '0;
            cur_val     <= '0;
            fail_cnt    <= '0;
            actuateLock <= 1'b1;
            openCls     <= 1'b0;
            lockout     <= 1'b0;
        end else begin
            case (fsm)
                LOCKED, PROGRAM: begin
                    timer <= '0;
                    if (lock_rise) begin
                        digit_idx <= '0;
                        cur_val   <= '0;
                        if (fsm == PROGRAM)
                            fsm <= OPEN;
                    end else if (open_rise) begin
                        // A same-cycle encoder step is dropped: the commit clears cur_val.
                        entry   <= new_code;
                        cur_val <= '0;
                        if (last_digit) begin
                            digit_idx <= '0;
                            if (fsm == LOCKED) begin
                                fsm <= CHECK;
                            end else begin
                                code <= new_code;
                                fsm  <= OPEN;
                            end
                        end else begin
                            digit_idx <= digit_idx + IDX_W'(1);
                        end
                    end else if (step_inc) begin
                        cur_val <= (cur_val == VAL_W'(DIGIT_MAX)) ? '0 : cur_val + VAL_W'(1);
                    end else if (step_dec) begin
                        cur_val <= (cur_val == '0) ? VAL_W'(DIGIT_MAX) : cur_val - VAL_W'(1);
                    end
                end

                CHECK: begin
                    timer <= '0;
                    if (match) begin
                        fsm         <= OPEN;
                        fail_cnt    <= '0;
                        actuateLock <= 1'b0;
                        openCls     <= 1'b1;
                    end else begin
                        fail_cnt <= fail_cnt + 3'd1;
                        if ((fail_cnt + 3'd1) == 3'(MAX_FAIL)) begin
                            fsm     <= LOCKOUT;
                            lockout <= 1'b1;
                        end else begin
                            fsm <= LOCKED;
                        end
                    end
                end

                OPEN: begin
                    // A bolt cannot be thrown into an open door, so lock only counts when closed.
                    if (lock_rise && door_s2) begin
                        fsm         <= LOCKED;
                        timer       <= '0;
                        actuateLock <= 1'b1;
                        openCls     <= 1'b0;
                    end else if (set_rise) begin
                        fsm       <= PROGRAM;
                        timer     <= '0;
                        digit_idx <= '0;
                        cur_val   <= '0;
                    end else if (!door_s2) begin
                        timer <= '0;
                    end else if (tick) begin
                        if (timer == TMR_W'(OPEN_TIMEOUT - 1)) begin
                            fsm         <= LOCKED;
                            timer       <= '0;
                            actuateLock <= 1'b1;
                            openCls     <= 1'b0;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                end

                LOCKOUT: begin
                    if (tick) begin
                        if (timer == TMR_W'(LOCKOUT_TICKS - 1)) begin
                            fsm      <= LOCKED;
                            timer    <= '0;
                            fail_cnt <= '0;
                            lockout  <= 1'b0;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                end

                default: begin
                    fsm         <= LOCKED;
                    timer       <= '0;
                    actuateLock <= 1'b1;
                    openCls     <= 1'b0;
                    lockout     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/safe_lock_ctrl.md
Name: safe_lock_ctrl

Overview:
Parametrised combination-safe controller, next generation of the safe top-level lock logic.
- Rotary quadrature encoder (a/b) dials each digit; the open button commits it.
- Adds configurable code length and digit range, failed-attempt lockout, auto-relock, and a user code-change mode.
- Drives the bolt actuator and exposes registered status for the LCD front-end; no LCD timing inside this block.

Parameters:
DIGITS, 3, number of digits in the code (1..8)
DIGIT_MAX, 39, highest dial value; digits range 0..DIGIT_MAX
VAL_W, 6, width of one digit value; must satisfy 2^VAL_W > DIGIT_MAX
MAX_FAIL, 3, consecutive wrong codes before lockout
LOCKOUT_TICKS, 30000, lockout duration in ticks
OPEN_TIMEOUT, 10000, ticks with door closed before auto-relock
div, 1, clk cycles per tick (tick prescaler; clk nominally 1 ms)
DEFAULT_CODE, {6'd5,6'd12,6'd30}, reset code, DIGITS*VAL_W bits, digit 0 in MSBs

Ports:
clk  in  1  system clock, single domain
reset  in  1  asynchronous, active-low reset
a  in  1  encoder channel A, asynchronous
b  in  1  encoder channel B, asynchronous
lock  in  1  lock / abort button, asynchronous, active-high
open  in  1  commit-digit button, asynchronous, active-high
doorCls  in  1  1 = door closed, asynchronous
set_code  in  1  enter code-change mode (only honoured in OPEN), asynchronous
actuateLock  out  1  1 = bolt extended
openCls  out  1  1 = bolt retracted (OPEN or PROGRAM)
state  out  3  current FSM state encoding
digit_idx  out  3  index of the digit being entered
cur_val  out  VAL_W  current dial value
fail_cnt  out  3  consecutive failures
lockout  out  1  1 while in LOCKOUT

Behaviour:
- Reset (asynchronous, active-low): state=LOCKED, code=DEFAULT_CODE, actuateLock=1, openCls=0, cur_val=0, digit_idx=0, fail_cnt=0, lockout=0, all timers and the prescaler at 0. Reset mid-operation aborts everything; a programmed code is lost and DEFAULT_CODE is restored.
- Input conditioning: every asynchronous input passes a 2-FF synchroniser. Buttons then go through a rising-edge detector. A pin first sampled high at edge k takes effect at edge k+2.
- Encoder: on a synchronised rising edge of a, b=0 increments cur_val and b=1 decrements it. Wrap: DIGIT_MAX+1 gives 0, and 0-1 gives DIGIT_MAX. The encoder is ignored in OPEN, CHECK and LOCKOUT.
- Tick: the prescaler counts 0..div-1 and emits a one-cycle tick at div-1. With div=1, every cycle is a tick.
- LOCKED: actuateLock=1.
  - open rise: entry[digit_idx]<=cur_val, cur_val<=0, digit_idx++. On the last digit, digit_idx<=0 and go to CHECK.
  - lock rise: clear the partial entry (digit_idx=0, cur_val=0).
- CHECK: one cycle, actuateLock=1.
  - Entry == code: go to OPEN, fail_cnt<=0.
  - Mismatch: fail_cnt++. If the new count equals MAX_FAIL, go to LOCKOUT; otherwise go to LOCKED.
- OPEN: actuateLock=0, openCls=1.
  - The relock timer counts ticks while doorCls=1 and clears while doorCls=0. At OPEN_TIMEOUT it goes to LOCKED.
  - lock rise with doorCls=1 goes to LOCKED immediately. lock rise with doorCls=0 is ignored, since an open door cannot be bolted.
  - set_code rise goes to PROGRAM, with digit_idx=0 and cur_val=0.
- PROGRAM: actuateLock=0, openCls=1. Digit entry works as in LOCKED. On the last commit, code<=entry and go to OPEN. lock rise aborts, keeps the old code and goes to OPEN. The relock timer is held at 0.
- LOCKOUT: actuateLock=1, lockout=1, all buttons and the encoder are ignored. After LOCKOUT_TICKS ticks, go to LOCKED with fail_cnt=0.
- Simultaneous events:
  - lock and open in the same cycle: lock wins.
  - Encoder step and open commit in the same cycle: the commit uses the pre-step value, cur_val becomes 0, and the step is dropped.
  - lock and set_code in the same cycle in OPEN: lock wins if doorCls=1, otherwise set_code wins.
- All outputs are registered; they reflect the state after each clk edge.

Decomposition:
- Package safe_pkg holds:
  - state encodings: LOCKED=0, CHECK=1, OPEN=2, PROGRAM=3, LOCKOUT=4;
  - the digit-index width constant;
  - a function that extracts digit i from a flat code vector.
- Sub-module quad_step: synchronisers plus edge detection on a/b, producing one-cycle inc/dec pulses.
- Button synchronisers and edge detectors stay inline.

Test Plan:
All scenarios use DIGITS=3, DIGIT_MAX=39, div=1, OPEN_TIMEOUT=50, LOCKOUT_TICKS=100, MAX_FAIL=3, DEFAULT_CODE=5,12,30.
1. Pulse reset low, then release -> actuateLock=1, openCls=0, state=0, cur_val=0, fail_cnt=0.
2. Dial 5 + open, 12 + open, 30 + open -> one CHECK cycle, then actuateLock=0, openCls=1, state=2.
3. From cur_val=0, one decrement step -> 39. From 0, 40 increments -> 0. A lock press mid-entry -> digit_idx=0.
4. Enter 1,1,1 three times -> fail_cnt=3, lockout=1, open presses ignored. After 100 cycles -> state=0, fail_cnt=0. Correct code then opens.
5. In OPEN with doorCls=0, press lock -> stays OPEN. Set doorCls=1 for 30 cycles, 0 for 5, then 1 for 50 -> relock occurs only after the final 50 closed cycles.
6. In OPEN, press set_code and enter 1,2,3 -> OPEN. Press lock -> LOCKED. Enter 5,12,30 -> fail. Enter 1,2,3 -> OPEN. Assert reset -> code back to 5,12,30.
